// File: rtl/dmem_responder.sv
// Data-memory responder for the core's mem_* port.
// The 32-bit word array is split into four byte-lane RAMs, so a store only
// touches the lanes it selects. After reset a sweep clears every word and
// then raises mem_ready. Loads return one clock later, right-aligned to the
// addressed byte.

// One byte lane of the word array: one write port, combinational read.
module dmem_lane #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH_WORDS];

  // Byte write. The array is deliberately not reset; the sweep clears it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-first: the registered consumer captures this value before the write
  // lands on the same edge.
  assign rdata = mem[raddr];
endmodule

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_w,
  input  logic [2:0]  mem_w_sel,
  input  logic [31:0] mem_in_data,
  output logic [31:0] mem_out_data_raw,
  output logic        mem_ready,
  output logic        mem_err
);
  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;

  localparam logic [2:0] SEL_SB = 3'b000;
  localparam logic [2:0] SEL_SH = 3'b001;
  localparam logic [2:0] SEL_SW = 3'b010;

  typedef enum logic {CLEAR, READY} state_t;

  state_t state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;

  logic [AW-1:0] idx;
  logic [1:0]    off;

  logic [NUM_LANES-1:0]       st_we;    // lanes a legal core store would write
  logic [NUM_LANES-1:0][7:0]  st_wd;    // per-lane store data
  logic                       st_bad;   // store request that must be rejected

  logic [NUM_LANES-1:0]       lane_we;
  logic [NUM_LANES-1:0][7:0]  lane_wd;
  logic [AW-1:0]              lane_waddr;
  logic [NUM_LANES-1:0][7:0]  lane_rd;
  logic [31:0]                rd_word;

  // Upper address bits are dropped, so addresses alias modulo the array size.
  assign idx = mem_addr[AW+1:2];
  assign off = mem_addr[1:0];

  assign mem_ready = (state == READY);

  // State and sweep-pointer register; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state: CLEAR walks every word once, then parks in READY.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == AW'(DEPTH_WORDS - 1)) state_nxt = READY;
      end
      READY: state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // Store decode: choose lanes and replicate the low data bits into them.
  // Anything misaligned or an unknown funct3 is flagged and writes nothing.
  always_comb begin
    st_we  = '0;
    st_bad = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) st_wd[i] = mem_in_data[8*i +: 8];
    case (mem_w_sel)
      SEL_SB: begin
        st_we[off] = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) st_wd[i] = mem_in_data[7:0];
      end
      SEL_SH: begin
        if (off[0]) begin
          st_bad = 1'b1;
        end else begin
          st_we = off[1] ? 4'b1100 : 4'b0011;
          for (int i = 0; i < NUM_LANES; i++) st_wd[i] = mem_in_data[8*(i%2) +: 8];
        end
      end
      SEL_SW: begin
        if (off != 2'b00) st_bad = 1'b1;
        else              st_we  = '1;
      end
      default: st_bad = 1'b1;
    endcase
  end

  // Write-port mux: the sweep owns the array in CLEAR; core stores in READY.
  // Nothing is written on a reset edge.
  always_comb begin
    lane_we    = '0;
    lane_wd    = '0;
    lane_waddr = idx;
    if (rst_n) begin
      if (state == CLEAR) begin
        lane_we    = '1;
        lane_waddr = ptr;
      end else if (mem_w) begin
        lane_we = st_we;
        lane_wd = st_wd;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dmem_lane #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (lane_we[g]),
      .waddr (lane_waddr),
      .wdata (lane_wd[g]),
      .raddr (idx),
      .rdata (lane_rd[g])
    );
  end

  assign rd_word = lane_rd;

  // Registered load data, shifted down to the addressed byte; held at zero
  // until the sweep completes. Alignment is never checked on reads.
  always_ff @(posedge clk) begin
    if (!rst_n)              mem_out_data_raw <= '0;
    else if (state == READY) mem_out_data_raw <= rd_word >> {off, 3'b000};
    else                     mem_out_data_raw <= '0;
  end

  // Sticky rejected-store flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)                               mem_err <= 1'b0;
    else if (state == READY && mem_w && st_bad) mem_err <= 1'b1;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a 16-word array.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_w;
  logic [2:0]  mem_w_sel;
  logic [31:0] mem_in_data;
  logic [31:0] mem_out_data_raw;
  logic        mem_ready;
  logic        mem_err;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.DEPTH_WORDS(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_addr         (mem_addr),
    .mem_w            (mem_w),
    .mem_w_sel        (mem_w_sel),
    .mem_in_data      (mem_in_data),
    .mem_out_data_raw (mem_out_data_raw),
    .mem_ready        (mem_ready),
    .mem_err          (mem_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs and checks happen 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] sel,
                       input logic [31:0] addr, input logic [31:0] data);
    mem_w       = w;
    mem_w_sel   = sel;
    mem_addr    = addr;
    mem_in_data = data;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'b010, 32'h8, 32'h0);
    step();
    chk("rst_out",   mem_out_data_raw, 32'h0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_err",   {31'd0, mem_err}, 32'd0);
    step();
    step();

    // Clear sweep: ready only after the 16th released edge; stores ignored.
    rst_n = 1'b1;
    drive(1'b1, 3'b011, 32'h8, 32'hFFFF_FFFF);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("sweep_ready_%0d", i), {31'd0, mem_ready}, {31'd0, i == 16});
      if (i < 16) chk($sformatf("sweep_out_%0d", i), mem_out_data_raw, 32'h0);
    end
    chk("sweep_err", {31'd0, mem_err}, 32'd0);

    for (int w = 0; w < 16; w++) begin
      drive(1'b0, 3'b000, 32'(w * 4), 32'h0);
      step();
      chk($sformatf("clr_word_%0d", w), mem_out_data_raw, 32'h0);
    end

    // Word store then load; the store edge itself still reads the old value.
    drive(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF);
    step();
    chk("sw_rd_first", mem_out_data_raw, 32'h0);
    drive(1'b0, 3'b010, 32'h8, 32'h0);
    step();
    chk("sw_load", mem_out_data_raw, 32'hDEAD_BEEF);

    // Byte and halfword lanes.
    drive(1'b1, 3'b000, 32'h9, 32'h1234_56A5);
    step();
    drive(1'b0, 3'b000, 32'h8, 32'h0);
    step();
    chk("sb_lane1", mem_out_data_raw, 32'hDEAD_A5EF);
    drive(1'b1, 3'b001, 32'hA, 32'hABCD_1234);
    step();
    drive(1'b0, 3'b000, 32'h8, 32'h0);
    step();
    chk("sh_half1", mem_out_data_raw, 32'h1234_A5EF);
    drive(1'b0, 3'b000, 32'hB, 32'h0);
    step();
    chk("rd_off3", mem_out_data_raw, 32'h0000_0012);
    drive(1'b0, 3'b000, 32'hA, 32'h0);
    step();
    chk("rd_off2", mem_out_data_raw, 32'h0000_1234);
    chk("err_clean", {31'd0, mem_err}, 32'd0);

    // Misaligned read with a word funct3 must not raise the error flag.
    drive(1'b0, 3'b010, 32'h6, 32'hFFFF_FFFF);
    step();
    chk("rd_mis_err", {31'd0, mem_err}, 32'd0);

    // Rejected stores: nothing written, flag sticks.
    drive(1'b1, 3'b010, 32'h6, 32'hFFFF_FFFF);
    step();
    chk("sw_mis_err", {31'd0, mem_err}, 32'd1);
    drive(1'b0, 3'b000, 32'h4, 32'h0);
    step();
    chk("sw_mis_nowr", mem_out_data_raw, 32'h0);
    drive(1'b1, 3'b001, 32'h5, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 3'b000, 32'h4, 32'h0);
    step();
    chk("sh_mis_nowr", mem_out_data_raw, 32'h0);
    drive(1'b1, 3'b011, 32'h4, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 3'b000, 32'h4, 32'h0);
    step();
    chk("sel011_nowr", mem_out_data_raw, 32'h0);
    chk("err_sticky", {31'd0, mem_err}, 32'd1);

    // Read-during-write on word 0x10.
    drive(1'b1, 3'b010, 32'h10, 32'h1111_1111);
    step();
    drive(1'b1, 3'b010, 32'h10, 32'h2222_2222);
    step();
    chk("rdw_old", mem_out_data_raw, 32'h1111_1111);
    drive(1'b0, 3'b010, 32'h10, 32'h0);
    step();
    chk("rdw_new", mem_out_data_raw, 32'h2222_2222);

    // Aliasing: 0x40 is word 0 in a 16-word array.
    drive(1'b1, 3'b010, 32'h40, 32'hAAAA_5555);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    step();
    chk("alias_w0", mem_out_data_raw, 32'hAAAA_5555);
    drive(1'b0, 3'b000, 32'h48, 32'h0);
    step();
    chk("alias_w2", mem_out_data_raw, 32'h1234_A5EF);

    // Reset mid-sweep: restarts the full 16-edge clear.
    rst_n = 1'b0;
    step();
    chk("rst2_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst2_err",   {31'd0, mem_err}, 32'd0);
    chk("rst2_out",   mem_out_data_raw, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("resweep_ready_%0d", i), {31'd0, mem_ready}, {31'd0, i == 16});
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0);
    step();
    chk("resweep_w0", mem_out_data_raw, 32'h0);
    drive(1'b0, 3'b000, 32'h10, 32'h0);
    step();
    chk("resweep_w4", mem_out_data_raw, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
